// File: rtl/button_peripheral_if.sv
// +----------------------------------------------------------------------------+
// | button_peripheral_if : processor data-bus slave port for button_peripheral |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface button_peripheral_if;
  logic        rd_en_i;
  logic        wr_en_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output rd_en_i, output wr_en_i, output addr_i, output data_i, input data_o);
  modport slave  (input rd_en_i, input wr_en_i, input addr_i, input data_i, output data_o);
endinterface

`default_nettype wire

// File: rtl/button_peripheral.sv
// +----------------------------------------------------------------------------+
// | button_peripheral : synchronized, debounced button inputs with sticky edge |
// | flags and maskable IRQ; optional FALL register under FALLING_EDGE_EN.      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module button_peripheral #(
  parameter int N_INPUTS        = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  button_peripheral_if.slave       bus,
  input  wire logic [N_INPUTS-1:0] btn_i,
  output logic                     irq_o
);

  localparam int                CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [4:0] OFF_STATE = 5'h00;
  localparam logic [4:0] OFF_RISE  = 5'h04;
  localparam logic [4:0] OFF_IRQEN = 5'h08;
  localparam logic [4:0] OFF_RAW   = 5'h0C;
  localparam logic [4:0] OFF_FALL  = 5'h10;

  logic [N_INPUTS-1:0] sync1;
  logic [N_INPUTS-1:0] raw;
  logic [N_INPUTS-1:0] state;
  logic [N_INPUTS-1:0] rise;
  logic [N_INPUTS-1:0] irqen;
  logic [N_INPUTS-1:0] accept;
  logic [N_INPUTS-1:0] pending;
  logic [4:0]          offset;
  logic [N_INPUTS-1:0] wdata;
  logic                unused_bits;

  assign offset      = bus.addr_i[4:0];
  assign wdata       = bus.data_i[N_INPUTS-1:0];
  assign unused_bits = ^{bus.addr_i[31:5], bus.data_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      raw   <= '0;
    end else begin
      sync1 <= btn_i;
      raw   <= sync1;
    end
  end

  // accept[i] marks the edge on which input i's debounced level flips.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;

    assign accept[i] = (raw[i] != state[i]) && (cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if ((raw[i] == state[i]) || accept[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Edge sets are OR-ed in after the W1C mask so a coincident event survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      rise  <= '0;
      irqen <= '0;
    end else begin
      state <= state ^ accept;
      rise  <= (rise & ~((bus.wr_en_i && offset == OFF_RISE) ? wdata : '0)) | (accept & ~state);
      if (bus.wr_en_i && offset == OFF_IRQEN) begin
        irqen <= wdata;
      end
    end
  end

`ifdef FALLING_EDGE_EN
  logic [N_INPUTS-1:0] fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall <= '0;
    end else begin
      fall <= (fall & ~((bus.wr_en_i && offset == OFF_FALL) ? wdata : '0)) | (accept & state);
    end
  end

  assign pending = (rise | fall) & irqen;
`else
  assign pending = rise & irqen;
`endif

  assign irq_o = |pending;

  always_comb begin
    bus.data_o = 32'h0;
    if (bus.rd_en_i) begin
      case (offset)
        OFF_STATE: bus.data_o = 32'(state);
        OFF_RISE:  bus.data_o = 32'(rise);
        OFF_IRQEN: bus.data_o = 32'(irqen);
        OFF_RAW:   bus.data_o = 32'(raw);
`ifdef FALLING_EDGE_EN
        OFF_FALL:  bus.data_o = 32'(fall);
`endif
        default:   bus.data_o = 32'h0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_peripheral.sv
// +----------------------------------------------------------------------------+
// | tb_button_peripheral : scoreboard bench for button_peripheral (N=8, DB=4)  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_button_peripheral;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn;
  logic       irq;

  button_peripheral_if bus ();

  button_peripheral #(.N_INPUTS(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .btn_i (btn),
    .irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop_check(input logic [31:0] act);
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      check("sb_empty", act, 32'hDEAD_BEEF);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, act, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    bus.rd_en_i = 1'b1;
    bus.addr_i  = addr;
    #2;
    sb_pop_check(bus.data_o);
    bus.rd_en_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_en_i = 1'b1;
    bus.addr_i  = addr;
    bus.data_i  = data;
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    bus.data_i  = 32'h0;
  endtask

  initial begin
    rst_n       = 1'b0;
    btn         = 8'hFF;
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.addr_i  = 32'h0;
    bus.data_i  = 32'h0;

    // reset state and post-reset latency
    repeat (3) tick();
    rd(32'h00, 32'h0, "rst_state");
    rd(32'h04, 32'h0, "rst_rise");
    rd(32'h08, 32'h0, "rst_irqen");
    rd(32'h0C, 32'h0, "rst_raw");
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    tick();
    rd(32'h0C, 32'h00, "raw_1clk");
    tick();
    rd(32'h0C, 32'hFF, "raw_2clk");
    repeat (3) tick();
    rd(32'h00, 32'h00, "state_5clk");
    tick();
    rd(32'h00, 32'hFF, "state_6clk");

    // return to idle, clear edge flags
    btn = 8'h00;
    repeat (10) tick();
    wr(32'h04, 32'hFF);
    rd(32'h00, 32'h00, "idle_state");
    rd(32'h04, 32'h00, "idle_rise");

    // clean press on input 0: exactly 6 edges
    btn[0] = 1'b1;
    repeat (5) tick();
    rd(32'h00, 32'h00, "db_5edges");
    tick();
    rd(32'h00, 32'h01, "db_6edges");
    rd(32'h04, 32'h01, "db_rise");

    // 3-cycle glitch on input 1 must be rejected
    btn[1] = 1'b1;
    repeat (3) tick();
    btn[1] = 1'b0;
    repeat (10) tick();
    rd(32'h00, 32'h01, "glitch_state");
    rd(32'h04, 32'h01, "glitch_rise");

    // interrupt enable / W1C
    wr(32'h08, 32'h01);
    check("irq_en_pending", 32'(irq), 32'h1);
    wr(32'h04, 32'h01);
    check("irq_cleared", 32'(irq), 32'h0);
    btn[0] = 1'b0;
    repeat (8) tick();
    btn[0] = 1'b1;
    repeat (8) tick();
    rd(32'h04, 32'h01, "irq_rise");
    check("irq_press", 32'(irq), 32'h1);
    wr(32'h04, 32'h00);
    rd(32'h04, 32'h01, "w0_rise");
    check("w0_irq", 32'(irq), 32'h1);
    wr(32'h04, 32'h01);
    rd(32'h04, 32'h00, "w1c_rise");
    check("w1c_irq", 32'(irq), 32'h0);

    // W1C collides with new rising event on input 2
    btn[2] = 1'b1;
    repeat (5) tick();
    rd(32'h00, 32'h01, "coll_pre_state");
    wr(32'h04, 32'h04);
    rd(32'h00, 32'h05, "coll_state");
    rd(32'h04, 32'h04, "coll_rise");
    check("coll_irq_masked", 32'(irq), 32'h0);
    wr(32'h04, 32'h04);
    rd(32'h04, 32'h00, "coll_clear");

    // address decode
    rd(32'h14, 32'h0, "dec_14");
    rd(32'h1C, 32'h0, "dec_1c");
    wr(32'h00, 32'hFF);
    rd(32'h00, 32'h05, "dec_state_ro");
    rd(32'hFFFF_FF00, 32'h05, "dec_upper_bits");
    bus.addr_i = 32'h0;
    #2;
    check("dec_rd_en_low", bus.data_o, 32'h0);

    // read during write returns pre-write value; IRQEN keeps only N bits
    bus.rd_en_i = 1'b1;
    bus.wr_en_i = 1'b1;
    bus.addr_i  = 32'h08;
    bus.data_i  = 32'hFFFF_FFFF;
    sb_push("rdwr_prewrite", 32'h01);
    #2;
    sb_pop_check(bus.data_o);
    tick();
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.data_i  = 32'h0;
    rd(32'h08, 32'hFF, "irqen_width");

    // falling edge on input 3
    btn[3] = 1'b1;
    repeat (8) tick();
    rd(32'h04, 32'h08, "fe_press_rise");
    wr(32'h04, 32'hFF);
    wr(32'h08, 32'h08);
    check("fe_irq_idle", 32'(irq), 32'h0);
    btn[3] = 1'b0;
    repeat (8) tick();
    rd(32'h00, 32'h05, "fe_state");
    rd(32'h04, 32'h00, "fe_rise");
`ifdef FALLING_EDGE_EN
    rd(32'h10, 32'h08, "fe_fall");
    check("fe_irq", 32'(irq), 32'h1);
    wr(32'h10, 32'h08);
    rd(32'h10, 32'h00, "fe_fall_clr");
    check("fe_irq_clr", 32'(irq), 32'h0);
`else
    rd(32'h10, 32'h00, "fe_fall_absent");
    check("fe_irq_absent", 32'(irq), 32'h0);
`endif

    // reset in the middle of a debounce
    btn[4] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rd(32'h00, 32'h00, "mid_rst_state");
    rd(32'h04, 32'h00, "mid_rst_rise");
    rd(32'h08, 32'h00, "mid_rst_irqen");
    check("mid_rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();
    rd(32'h00, 32'h00, "post_rst_5");
    tick();
    rd(32'h00, 32'h15, "post_rst_6");
    rd(32'h04, 32'h15, "post_rst_rise");

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
